// File: rtl/vx_rop_req_arb_pkg.sv
// Shared types and width helpers for the ROP request arbiter.
// The request payload mirrors the per-agent rop request fields.
package vx_rop_req_arb_pkg;

  localparam int NUM_THREADS    = 4;
  localparam int UUID_WIDTH     = 16;
  localparam int ROP_DIM_BITS   = 12;
  localparam int ROP_DEPTH_BITS = 24;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]                          uuid;
    logic [NUM_THREADS-1:0]                         mask;
    logic [NUM_THREADS-1:0][ROP_DIM_BITS-1:0]       pos_x;
    logic [NUM_THREADS-1:0][ROP_DIM_BITS-1:0]       pos_y;
    logic [NUM_THREADS-1:0][31:0]                   color;
    logic [NUM_THREADS-1:0][ROP_DEPTH_BITS-1:0]     depth;
    logic [NUM_THREADS-1:0]                         face;
  } rop_req_data_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int burst_cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/vx_rop_req_arb_rr_pick.sv
// Combinational wrap-around priority picker: first valid index at or above
// rr_ptr, wrapping to zero.
module vx_rop_req_arb_rr_pick
  import vx_rop_req_arb_pkg::*;
#(
  parameter int NUM_REQS = 4,
  localparam int IDX_W   = idx_width(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] valid,
  input  logic [IDX_W-1:0]    rr_ptr,
  output logic [IDX_W-1:0]    idx,
  output logic                found
);

  always_comb begin
    int j;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      j = (int'(rr_ptr) + i) % NUM_REQS;
      if (!found && valid[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/vx_skid_buffer.sv
// Two-entry skid buffer: registered output stage plus one overflow slot,
// so the upstream ready is a plain register output.
module vx_skid_buffer #(
  parameter int DATA_W  = 8,
  parameter int OUT_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [DATA_W-1:0] data_out
);

  if (OUT_REG != 0) begin : g_reg
    logic              vld_p1, vld_skid;
    logic [DATA_W-1:0] data_p1, data_skid;
    logic              stall;

    assign stall     = vld_p1 && !ready_out;
    assign ready_in  = !vld_skid;
    assign valid_out = vld_p1;
    assign data_out  = data_p1;

    always_ff @(posedge clk) begin
      if (!reset) begin
        vld_p1   <= 1'b0;
        vld_skid <= 1'b0;
      end else if (stall) begin
        if (valid_in && ready_in) vld_skid <= 1'b1;
      end else begin
        vld_p1   <= vld_skid || valid_in;
        vld_skid <= 1'b0;
      end
    end

    // Output stage: overflow slot drains first so order is preserved
    always_ff @(posedge clk) begin
      if (stall) begin
        if (valid_in && ready_in) data_skid <= data_in;
      end else begin
        data_p1 <= vld_skid ? data_skid : data_in;
      end
    end
  end else begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign ready_in  = ready_out;
    assign valid_out = valid_in;
    assign data_out  = data_in;
  end

endmodule

// File: rtl/vx_rop_req_arb.sv
// Round-robin arbiter with burst lock sharing one ROP request port among
// NUM_REQS agents; zero-mask beats are consumed but never forwarded.
module vx_rop_req_arb
  import vx_rop_req_arb_pkg::*;
#(
  parameter int NUM_REQS  = 4,
  parameter int MAX_BURST = 4,
  parameter int OUT_REG   = 1,
  localparam int IDX_W    = idx_width(NUM_REQS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQS-1:0]          in_valid,
  input  rop_req_data_t [NUM_REQS-1:0] in_data,
  output logic [NUM_REQS-1:0]          in_ready,
  output logic                         out_valid,
  output rop_req_data_t                out_data,
  input  logic                         out_ready,
  output logic [IDX_W-1:0]             grant_idx,
  output logic [31:0]                  perf_stalls
);

  localparam int BCNT_W = burst_cnt_width(MAX_BURST);

  arb_state_e        state, state_n;
  logic [IDX_W-1:0]  rr_ptr, rr_ptr_n, grant_n, pick_idx, sel_idx;
  logic [BCNT_W-1:0] burst_cnt, burst_n, burst_inc;
  logic              pick_found, sel_valid, sel_ready, sel_zero;
  logic              fire, push, buf_ready;
  rop_req_data_t     sel_data;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQS - 1)) ? '0 : i + 1'b1;
  endfunction

  vx_rop_req_arb_rr_pick #(.NUM_REQS(NUM_REQS)) u_pick (
    .valid  (in_valid),
    .rr_ptr (rr_ptr),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      burst_cnt   <= '0;
      grant_idx   <= '0;
      perf_stalls <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      burst_cnt <= burst_n;
      grant_idx <= grant_n;
      if ((|in_valid) && !fire) perf_stalls <= perf_stalls + 32'd1;
    end
  end

  always_comb begin
    state_n   = state;
    rr_ptr_n  = rr_ptr;
    burst_n   = burst_cnt;
    grant_n   = grant_idx;
    burst_inc = burst_cnt + 1'b1;
    case (state)
      IDLE: begin
        if (fire) begin
          grant_n = pick_idx;
          burst_n = BCNT_W'(1);
          if (MAX_BURST > 1) state_n = LOCK;
          else rr_ptr_n = wrap_inc(pick_idx);
        end
      end
      LOCK: begin
        // A locked agent that goes idle gives up the port immediately
        if (!in_valid[grant_idx]) begin
          rr_ptr_n = wrap_inc(grant_idx);
          state_n  = IDLE;
        end else if (fire) begin
          if (burst_inc == BCNT_W'(MAX_BURST)) begin
            rr_ptr_n = wrap_inc(grant_idx);
            state_n  = IDLE;
          end else begin
            burst_n = burst_inc;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Zero-mask beats are swallowed here, so they never wait on the buffer
  always_comb begin
    sel_idx   = (state == IDLE) ? pick_idx : grant_idx;
    sel_data  = in_data[sel_idx];
    sel_valid = (state == IDLE) ? pick_found : in_valid[sel_idx];
    sel_zero  = (sel_data.mask == '0);
    sel_ready = reset && ((state == LOCK) || pick_found) && (sel_zero || buf_ready);
    in_ready  = '0;
    in_ready[sel_idx] = sel_ready;
    fire      = sel_valid && sel_ready;
    push      = fire && !sel_zero;
  end

  vx_skid_buffer #(
    .DATA_W  ($bits(rop_req_data_t)),
    .OUT_REG (OUT_REG)
  ) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (push),
    .ready_in  (buf_ready),
    .data_in   (sel_data),
    .valid_out (out_valid),
    .ready_out (out_ready),
    .data_out  (out_data)
  );

endmodule

// File: tb/tb_vx_rop_req_arb.sv
// Directed bench for vx_rop_req_arb: three instances (MAX_BURST 1, 2, 4)
// share the request bus; each step checks the instance it targets.
module tb_vx_rop_req_arb;
  import vx_rop_req_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]          in_valid;
  rop_req_data_t [3:0] in_data;
  logic                out_ready;

  logic [3:0]    rdy1, rdy2, rdy4;
  logic          ov1, ov2, ov4;
  rop_req_data_t od1, od2, od4;
  logic [1:0]    g1, g2, g4;
  logic [31:0]   ps1, ps2, ps4;

  int errors = 0;
  int checks = 0;

  vx_rop_req_arb #(.NUM_REQS(4), .MAX_BURST(1), .OUT_REG(1)) d1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
    .out_valid(ov1), .out_data(od1), .out_ready(out_ready), .grant_idx(g1), .perf_stalls(ps1));
  vx_rop_req_arb #(.NUM_REQS(4), .MAX_BURST(2), .OUT_REG(1)) d2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy2),
    .out_valid(ov2), .out_data(od2), .out_ready(out_ready), .grant_idx(g2), .perf_stalls(ps2));
  vx_rop_req_arb #(.NUM_REQS(4), .MAX_BURST(4), .OUT_REG(1)) d4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy4),
    .out_valid(ov4), .out_data(od4), .out_ready(out_ready), .grant_idx(g4), .perf_stalls(ps4));

  function automatic rop_req_data_t mk(input logic [15:0] u, input logic [3:0] m);
    rop_req_data_t d;
    d      = '0;
    d.uuid = u;
    d.mask = m;
    for (int t = 0; t < NUM_THREADS; t++) begin
      d.pos_x[t] = 12'(u + 16'(t));
      d.pos_y[t] = 12'(u ^ 16'(t * 5));
      d.color[t] = {16'hC0DE, u};
      d.depth[t] = 24'(u * 3 + 16'(t));
      d.face[t]  = u[t];
    end
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input rop_req_data_t obs, input rop_req_data_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed uuid=%0h mask=%0h expected uuid=%0h mask=%0h",
             tag, obs.uuid, obs.mask, exp.uuid, exp.mask);
    end
  endtask

  initial begin
    int seq;
    int nexp;
    logic r;
    int exp_g[9];

    // Pure round-robin, all agents streaming
    reset     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'hF;
    for (int i = 0; i < 4; i++) in_data[i] = mk(16'(i), 4'hF);
    #2;
    chk("rst_ready", 64'(rdy1), 64'h0);
    tick();
    tick();
    reset = 1'b1;
    chk("rst_out_valid", 64'(ov1), 64'h0);
    chk("rst_perf", 64'(ps1), 64'h0);
    chk("rst_grant", 64'(g1), 64'h0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr1_grant", 64'(g1), 64'(k % 4));
      chk("rr1_valid", 64'(ov1), 64'h1);
      chk_data("rr1_data", od1, mk(16'(k % 4), 4'hF));
    end

    // Burst lock with agents 0 and 2
    in_valid = 4'b0101;
    do_reset();
    exp_g = '{0, 0, 0, 0, 2, 2, 2, 2, 0};
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("burst_grant", 64'(g4), 64'(exp_g[k]));
      chk_data("burst_data", od4, mk(16'(exp_g[k]), 4'hF));
    end

    // Early release: agent 1 drops valid after two beats
    in_valid = 4'b1010;
    do_reset();
    tick();
    chk("rel_grant1", 64'(g4), 64'd1);
    chk_data("rel_data1", od4, mk(16'd1, 4'hF));
    tick();
    chk_data("rel_data2", od4, mk(16'd1, 4'hF));
    in_valid = 4'b1000;
    tick();
    chk("rel_bubble", 64'(ov4), 64'h0);
    chk("rel_rr_ptr", 64'(d4.rr_ptr), 64'd2);
    chk("rel_state", 64'(d4.state), 64'(IDLE));
    tick();
    chk("rel_grant3", 64'(g4), 64'd3);
    chk("rel_valid3", 64'(ov4), 64'h1);
    chk_data("rel_data3", od4, mk(16'd3, 4'hF));
    chk("rel_perf", 64'(ps4), 64'd1);

    // Backpressure: agent 0 streams into a stalled port, then drains
    in_valid   = 4'b0001;
    seq        = 0;
    in_data[0] = mk(16'h100, 4'hF);
    out_ready  = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      r = rdy4[0];
      tick();
      if (r) begin
        seq++;
        in_data[0] = mk(16'(16'h100 + seq), 4'hF);
      end
    end
    chk("bp_accepted", 64'(seq), 64'd2);
    chk("bp_ready", 64'(rdy4), 64'h0);
    chk("bp_out_valid", 64'(ov4), 64'h1);
    chk_data("bp_head", od4, mk(16'h100, 4'hF));
    chk("bp_perf", 64'(ps4), 64'd3);
    out_ready = 1'b1;
    nexp = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      r = rdy4[0];
      if (ov4) begin
        chk_data("drain_order", od4, mk(16'(16'h100 + nexp), 4'hF));
        nexp++;
      end
      tick();
      if (r) begin
        seq++;
        in_data[0] = mk(16'(16'h100 + seq), 4'hF);
      end
    end
    chk("drain_count", 64'(nexp), 64'd8);
    chk("drain_accepted", 64'(seq), 64'd9);

    // Zero-mask beat on the MAX_BURST=2 instance
    in_valid   = 4'b0100;
    in_data[2] = mk(16'h200, 4'hF);
    do_reset();
    tick();
    chk("zm_grant", 64'(g2), 64'd2);
    chk("zm_valid1", 64'(ov2), 64'h1);
    chk_data("zm_data1", od2, mk(16'h200, 4'hF));
    in_data[2] = mk(16'h201, 4'h0);
    @(negedge clk);
    chk("zm_ready", 64'(rdy2), 64'b0100);
    tick();
    chk("zm_dropped", 64'(ov2), 64'h0);
    chk("zm_state", 64'(d2.state), 64'(IDLE));
    chk("zm_rr_ptr", 64'(d2.rr_ptr), 64'd3);
    chk("zm_perf", 64'(ps2), 64'd0);
    in_data[2] = mk(16'h202, 4'hF);
    tick();
    chk("zm_valid3", 64'(ov2), 64'h1);
    chk_data("zm_data3", od2, mk(16'h202, 4'hF));

    // Mid-operation reset while LOCK holds a full buffer
    in_valid   = 4'b0101;
    in_data[0] = mk(16'h300, 4'hF);
    in_data[2] = mk(16'h302, 4'hF);
    out_ready  = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) tick();
    chk("mr_state", 64'(d4.state), 64'(LOCK));
    chk("mr_burst", 64'(d4.burst_cnt), 64'd2);
    chk("mr_full_ready", 64'(rdy4), 64'h0);
    chk("mr_perf_pre", 64'(ps4), 64'd2);
    reset = 1'b0;
    #1;
    chk("mr_rst_ready", 64'(rdy4), 64'h0);
    tick();
    reset = 1'b1;
    chk("mr_out_valid", 64'(ov4), 64'h0);
    chk("mr_perf", 64'(ps4), 64'd0);
    chk("mr_grant", 64'(g4), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("mr_regrant", 64'(g4), 64'd0);
    chk("mr_valid", 64'(ov4), 64'h1);
    chk_data("mr_data", od4, mk(16'h300, 4'hF));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
